// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/multu/div/divu, HI/LO registers,
// mthi/mtlo writes and mfhi/mflo reads.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  mdu_op,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic [CW-1:0] cnt;
    logic [31:0]   res_hi, res_lo;
    logic          res_we;

    logic          is_mul, is_div;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   divisor, a_abs, b_abs, q_mag, r_mag;
    logic [31:0]   quot_s, rem_s, quot_u, rem_u;
    logic [31:0]   nxt_hi, nxt_lo;

    assign is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    assign is_div = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    assign start  = (is_mul || is_div) && !busy;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Zero divisor is replaced by 1 so the datapath never produces X; the result is discarded.
    assign divisor = (B == 32'd0) ? 32'd1 : B;
    assign quot_u  = A / divisor;
    assign rem_u   = A % divisor;

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_abs  = A[31] ? (~A + 32'd1) : A;
    assign b_abs  = divisor[31] ? (~divisor + 32'd1) : divisor;
    assign q_mag  = a_abs / b_abs;
    assign r_mag  = a_abs % b_abs;
    assign quot_s = (A[31] ^ divisor[31]) ? (~q_mag + 32'd1) : q_mag;
    assign rem_s  = A[31] ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        nxt_hi = 32'd0;
        nxt_lo = 32'd0;
        case (mdu_op)
            OP_MULT:  begin nxt_hi = prod_s[63:32]; nxt_lo = prod_s[31:0]; end
            OP_MULTU: begin nxt_hi = prod_u[63:32]; nxt_lo = prod_u[31:0]; end
            OP_DIV:   begin nxt_hi = rem_s;         nxt_lo = quot_s;       end
            OP_DIVU:  begin nxt_hi = rem_u;         nxt_lo = quot_u;       end
            default:  ;
        endcase
    end

    always_comb begin
        mdu_out = 32'd0;
        if (mdu_op == OP_MFHI)
            mdu_out = HI;
        else if (mdu_op == OP_MFLO)
            mdu_out = LO;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HI     <= 32'd0;
            LO     <= 32'd0;
            busy   <= 1'b0;
            cnt    <= '0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_we <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                if (res_we) begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
            end
        end else if (start) begin
            res_hi <= nxt_hi;
            res_lo <= nxt_lo;
            res_we <= !(is_div && (B == 32'd0));
            cnt    <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy   <= 1'b1;
        end else if (mdu_op == OP_MTHI) begin
            HI <= A;
        end else if (mdu_op == OP_MTLO) begin
            LO <= A;
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected HI/LO queued at start, popped when busy drops.
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  mdu_op;
    logic        start, busy;
    logic [31:0] HI, LO, mdu_out;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb_q[$];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .mdu_op(mdu_op),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, optionally presenting inj_op during the busy window.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int ncyc, input logic [3:0] inj_op);
        int n;
        logic [63:0] e;
        mdu_op = op; A = a; B = b;
        #1;
        chk({tag, ".start"}, {31'd0, start}, 32'd1);
        sb_q.push_back({ehi, elo});
        tick();
        mdu_op = inj_op;
        if (inj_op == 4'd5 || inj_op == 4'd6) A = 32'd1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            #1;
            if (inj_op >= 4'd1 && inj_op <= 4'd4)
                chk({tag, ".start_busy"}, {31'd0, start}, 32'd0);
            n++;
            @(posedge clk);
            #1;
        end
        mdu_op = 4'd0;
        chk({tag, ".busy_cycles"}, n, ncyc);
        chk({tag, ".busy_clr"}, {31'd0, busy}, 32'd0);
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".HI"}, HI, e[63:32]);
            chk({tag, ".LO"}, LO, e[31:0]);
        end
    endtask

    initial begin
        reset = 1'b1; mdu_op = 4'd0; A = 32'd0; B = 32'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst.HI", HI, 32'd0);
        chk("rst.LO", LO, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.start", {31'd0, start}, 32'd0);
        chk("rst.out", mdu_out, 32'd0);

        run_op("mult",   4'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 4'd0);
        run_op("multu",  4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 4'd0);
        run_op("div",    4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 4'd0);
        run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 4'd0);
        run_op("divu",   4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, 4'd0);

        mdu_op = 4'd5; A = 32'h11; tick();
        mdu_op = 4'd6; A = 32'h22; tick();
        mdu_op = 4'd0;
        run_op("divu0",  4'd4, 32'd7, 32'd0, 32'h11, 32'h22, 10, 4'd0);

        mdu_op = 4'd5; A = 32'hAAAA; tick();
        mdu_op = 4'd6; A = 32'h5555; tick();
        mdu_op = 4'd0;
        chk("mthi.HI", HI, 32'hAAAA);
        chk("mtlo.LO", LO, 32'h5555);
        mdu_op = 4'd7; #1; chk("mfhi", mdu_out, 32'hAAAA);
        mdu_op = 4'd8; #1; chk("mflo", mdu_out, 32'h5555);
        mdu_op = 4'd0; #1; chk("op0", mdu_out, 32'd0);
        mdu_op = 4'd9; #1; chk("op9", mdu_out, 32'd0);
        chk("op9.start", {31'd0, start}, 32'd0);
        mdu_op = 4'd0;

        run_op("mult_neg",  4'd1, 32'hFFFFFFFE, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF2, 5, 4'd6);
        run_op("multu_big", 4'd2, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 5, 4'd5);

        // Reset during the 4th busy cycle abandons the divide.
        mdu_op = 4'd3; A = 32'd100; B = 32'd7;
        tick();
        mdu_op = 4'd0;
        tick(); tick(); tick();
        chk("rstmid.busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid.HI", HI, 32'd0);
        chk("rstmid.LO", LO, 32'd0);
        chk("rstmid.busy", {31'd0, busy}, 32'd0);
        repeat (12) tick();
        chk("rstmid.late_HI", HI, 32'd0);
        chk("rstmid.late_LO", LO, 32'd0);

        // Back-to-back: op held at mult through busy, second start lands at t+6.
        run_op("b2b_1", 4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5, 4'd1);
        run_op("b2b_2", 4'd1, 32'd5, 32'd6, 32'd0, 32'd30, 5, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage, alongside the integer ALU.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO architectural registers.
- Services mthi/mtlo writes and mfhi/mflo reads.
- mdu_out joins the ALU result in the E-stage result mux feeding the E/M register.
- start|busy drives the hazard unit: any MDU instruction in D stalls while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu; must be ≥1.
- DIV_CYCLES, 10, busy duration for div/divu; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- mdu_op  input  4  E-stage op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 none. A flushed or bubbled E stage presents 0.
- start  output  1  combinational; 1 when mdu_op∈{1..4} and busy=0.
- busy  output  1  registered; 1 while an operation is in flight.
- HI  output  32  registered HI.
- LO  output  32  registered LO.
- mdu_out  output  32  combinational; HI if mdu_op=7, LO if mdu_op=8, else 0.

Behaviour:
- Reset
  - Synchronous, active-high, at posedge clk with reset=1.
  - HI=0, LO=0, busy=0, cnt=0, pending results=0.
  - Any in-flight operation is abandoned; its result is never written.
  - Reset has priority over every other action in that cycle.
- Start
  - Occurs at a posedge with start=1; call it cycle t.
  - Compute the result from A/B sampled at that edge and hold it in internal regs res_hi/res_lo.
  - Load cnt = MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Set busy=1.
- Operation arithmetic
  - mult: signed 32×32 product, 64-bit; HI=[63:32], LO=[31:0].
  - multu: unsigned 32×32 product, 64-bit; HI=[63:32], LO=[31:0].
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned; LO = quotient, HI = remainder.
  - Divide by zero (B=0, div or divu): the operation still occupies busy for DIV_CYCLES; HI and LO stay unchanged at completion.
- Busy window and commit
  - Each posedge with busy=1 decrements cnt.
  - At the edge where cnt==1: commit res_hi/res_lo to HI/LO, clear busy, cnt becomes 0.
  - busy is high for exactly N cycles, t+1 .. t+N.
  - New HI/LO values are visible from cycle t+N+1; busy=0 in that same cycle.
- mthi/mtlo
  - At a posedge with busy=0 and mdu_op=5: HI←A, LO unchanged.
  - At a posedge with busy=0 and mdu_op=6: LO←A, HI unchanged.
- While busy=1
  - mdu_op 1–6 are ignored (no restart, no HI/LO write). The hazard unit guarantees they do not occur; this rule is defensive only.
  - mfhi/mflo during busy return the old HI/LO; the hazard unit stalls them.
- Back-to-back
  - A new start is accepted in the first cycle with busy=0, i.e. t+N+1, and uses the freshly committed state.
- Reads
  - mdu_out is purely combinational from the registered HI/LO.
  - There is no bypass from res_hi/res_lo.

Test Plan:
- Reset, then mult with A=0xFFFFFFFF, B=2.
  - Expect busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
- multu with A=0xFFFFFFFF, B=2.
  - Expect HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div with A=0xFFFFFFF9 (−7), B=2.
  - Expect busy for 10 cycles.
  - Then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- div/divu edge cases:
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu A=7, B=0 with prior HI=0x11, LO=0x22 → busy 10 cycles, then HI/LO still 0x11/0x22.
- Ignored ops and reads:
  - mthi A=0xAAAA then mtlo A=0x5555 → HI=0xAAAA, LO=0x5555.
  - mfhi → mdu_out=0xAAAA; mflo → mdu_out=0x5555; op=0 → mdu_out=0.
  - mtlo A=1 issued during busy → ignored.
- Reset mid-operation, then back-to-back start:
  - Start div, assert reset in busy cycle 4 → HI=LO=0, busy=0 next cycle, no late commit.
  - Then two mults presented back-to-back → second start accepted at t+6 only, start=0 while busy.
